alu_ext: RTL
============

# alu_ext

Parametrised ALU for the multicycle MIPS core: combinational integer ops plus an iterative multiply/divide unit that writes internal HI/LO registers. Sits in the execute stage; the multicycle controller starts MULT/DIV ops with a handshake and stalls on `busy_o` before issuing MFHI/MFLO.

## Interface
- `WIDTH`, 32: datapath width; power of two, at least 8.
- `SHW`, `$clog2(WIDTH)`: shift-amount width, derived; do not override.

- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `a_i` in WIDTH: operand A.
- `b_i` in WIDTH: operand B; its low SHW bits are the shift amount.
- `funct_i6` in 6: MIPS R-type funct.
- `alt_ctrl_i2` in 2: fallback op when funct is not decoded.
- `start_i` in 1: request a MULT/MULTU/DIV/DIVU.
- `y_o` out WIDTH: result.
- `zero_o` out 1: `y_o == 0`.
- `ovf_o` out 1: signed overflow for ADD/SUB only.
- `busy_o` out 1: iterative op in progress.
- `done_o` out 1: one-cycle pulse when HI/LO are written.

## Operation
- Combinational funct decode drives `y_o`:
  - ADD 100000 / ADDU 100001: a+b.
  - SUB 100010 / SUBU 100011: a−b.
  - AND 100100, OR 100101, XOR 100110, NOR 100111.
  - SLT 101010: signed compare; SLTU 101011: unsigned compare; result is 1 or 0.
  - SLL 000000: a<<b[SHW-1:0]; SRL 000010: logical right shift; SRA 000011: arithmetic right shift.
  - MFHI 010000 → HI; MFLO 010010 → LO.
  - MULT/MULTU/DIV/DIVU (011000–011011) → y_o = 0.
- Undecoded funct falls back to `alt_ctrl_i2`: 00 ADD, 01 SUB, 10 SLT (signed), 11 → y_o = 0. X is never driven.
- `ovf_o` is set only for ADD and SUB, and for the alt-ctrl ADD/SUB; it is 0 for all other ops.
- Accepting a multi-cycle op:
  - Accepted when `start_i`=1, state IDLE and funct is MULT/MULTU/DIV/DIVU.
  - Operands and signedness are latched at acceptance.
  - Signed ops work on magnitudes and fix the sign at the end.
- FSM states are IDLE, MUL and DIV. A WIDTH-step counter drives MUL/DIV back to IDLE.
  - MUL: radix-2 shift-add; HI:LO = full 2·WIDTH product.
  - DIV: restoring division. LO = quotient, truncated toward zero; HI = remainder, with the sign of the dividend.
- DIV/DIVU with divisor 0: LO = all ones, HI = a. Latency is unchanged.
- DIV of MIN by −1: LO = MIN, HI = 0.
- Reset: state IDLE, HI = LO = 0, `busy_o` = 0, `done_o` = 0. `y_o`, `zero_o` and `ovf_o` are combinational, so after reset MFHI/MFLO read 0.

## Timing
- Combinational ops: result on `y_o` in the same cycle; no register stage.
- Acceptance at edge k:
  - `busy_o` = 1 after edge k through edge k+WIDTH−1.
  - At edge k+WIDTH: HI/LO are written, `busy_o` falls and `done_o` = 1 for exactly one cycle.
- `start_i` while busy is ignored. No queuing; the in-flight op continues unaffected.
- A new op can be accepted in the same cycle `done_o` is high (state is already IDLE).
- MFHI/MFLO while busy return the old HI/LO.
- `rst_i` mid-operation aborts immediately: no `done_o`, HI/LO cleared.
- Operand inputs may change after acceptance without effect.

## Configuration
- `ALU_DIV_EN` defined: the divider and the DIV state are built.
- `ALU_DIV_EN` not defined:
  - DIV/DIVU are never accepted: `busy_o` stays 0 and HI/LO are unchanged.
  - `y_o` = 0 for those functs.
  - MULT/MULTU are unaffected.

## Structure
- Package `alu_ext_pkg` holds:
  - funct constants, as 6-bit localparams;
  - alt-ctrl enum (ADD, SUB, SLT, NONE);
  - FSM state enum (IDLE, MUL, DIV).
- Sub-module `alu_muldiv` owns the FSM, counter, HI/LO, `busy_o` and `done_o`. Its divider datapath sits inside an `ifdef ALU_DIV_EN`.
- The top level holds the combinational decode and the MFHI/MFLO mux.

## Test plan
Each line is stimulus → required response, with WIDTH=32.
- ADD a=0x7FFFFFFF, b=1 → y=0x80000000, ovf=1, zero=0. SUBU a=5, b=5 → y=0, zero=1, ovf=0.
- SRA a=0x80000000, b=4 → y=0xF8000000. SLTU a=1, b=0xFFFFFFFF → 1. SLT with the same operands → 0. funct 111111 with alt=11 → y=0.
- MULT a=0xFFFFFFFD, b=7, start at edge k:
  - busy from k to k+31; done pulse after edge k+32;
  - HI=0xFFFFFFFF, LO=0xFFFFFFEB; MFLO then gives y=0xFFFFFFEB.
- DIV a=−7, b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=9, b=0 → LO=0xFFFFFFFF, HI=9, same 32-cycle latency.
- MULTU 3×5 started, then start DIV at cycle 5 → ignored, result HI=0, LO=15. rst_i at cycle 10 of a second MULTU → busy=0 immediately, no done pulse, MFHI=0.
- Build without `ALU_DIV_EN`: DIV start → busy stays 0, no done, HI/LO keep their previous values.

Source files
------------

// File: rtl/alu_ext_pkg.sv
// Shared decode constants, alt-ctrl and FSM encodings for the execute-stage ALU.
package alu_ext_pkg;

    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;

    typedef enum logic [1:0] {
        ALT_ADD  = 2'b00,
        ALT_SUB  = 2'b01,
        ALT_SLT  = 2'b10,
        ALT_NONE = 2'b11
    } alt_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10
    } state_e;

    // Two's-complement overflow from the operand and result sign bits.
    function automatic logic signed_ovf(input logic a_s, input logic b_s,
                                        input logic r_s, input logic sub);
        return ((a_s ^ b_s) == sub) && (r_s != a_s);
    endfunction

endpackage

// File: rtl/alu_ext_if.sv
// Operand/op request and result bundle between the execute controller and the ALU.
interface alu_ext_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic [5:0]       funct_i6;
    logic [1:0]       alt_ctrl_i2;
    logic             start_i;
    logic [WIDTH-1:0] y_o;
    logic             zero_o;
    logic             ovf_o;
    logic             busy_o;
    logic             done_o;

    modport master (
        output a_i, b_i, funct_i6, alt_ctrl_i2, start_i,
        input  y_o, zero_o, ovf_o, busy_o, done_o
    );

    modport slave (
        input  a_i, b_i, funct_i6, alt_ctrl_i2, start_i,
        output y_o, zero_o, ovf_o, busy_o, done_o
    );
endinterface

// File: rtl/alu_muldiv.sv
// Iterative MULT/MULTU (+ DIV/DIVU when ALU_DIV_EN is defined) writing HI/LO.
// Latency: HI/LO written WIDTH cycles after acceptance, with a one-cycle done_o.
// Backpressure: start_i is only honoured in IDLE; requests while busy_o are dropped.
module alu_muldiv
    import alu_ext_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             busy_o,
    output logic             done_o
);
    localparam int CW = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   acc_hi_q, acc_lo_q, opnd_q, hi_q, lo_q;
    logic               neg_q, done_q;
    logic               accept, last, op_signed;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_acc_n, mul_res;

    assign op_signed = ~op_i[0];
    assign a_mag     = (op_signed && a_i[WIDTH-1]) ? -a_i : a_i;
    assign b_mag     = (op_signed && b_i[WIDTH-1]) ? -b_i : b_i;
    assign last      = (cnt_q == CW'(WIDTH-1));

`ifdef ALU_DIV_EN
    assign accept = start_i && (state_q == IDLE);
`else
    assign accept = start_i && (state_q == IDLE) && !op_i[1];
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (accept) state_d = op_i[1] ? DIV : MUL;
            MUL, DIV: if (last) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Multiplier sits in acc_lo and shifts out as the partial product shifts in.
    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
        mul_acc_n = {mul_sum, acc_lo_q[WIDTH-1:1]};
        mul_res   = neg_q ? -mul_acc_n : mul_acc_n;
    end

`ifdef ALU_DIV_EN
    logic [WIDTH:0]   div_shift, div_diff;
    logic [WIDTH-1:0] rem_n, quo_n, div_hi, div_lo, a_orig_q;
    logic             rem_neg_q, div0_q;

    // Restoring step: remainder in acc_hi, dividend shifting out of acc_lo as quotient shifts in.
    always_comb begin
        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (!div_diff[WIDTH]) begin
            rem_n = div_diff[WIDTH-1:0];
            quo_n = {acc_lo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_n = div_shift[WIDTH-1:0];
            quo_n = {acc_lo_q[WIDTH-2:0], 1'b0};
        end
        if (div0_q) begin
            div_lo = '1;
            div_hi = a_orig_q;
        end else begin
            div_lo = neg_q ? -quo_n : quo_n;
            div_hi = rem_neg_q ? -rem_n : rem_n;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
            a_orig_q  <= '0;
        end else if (accept) begin
            rem_neg_q <= op_signed && a_i[WIDTH-1];
            div0_q    <= (b_i == '0);
            a_orig_q  <= a_i;
        end
    end
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        cnt_q    <= '0;
                        acc_hi_q <= '0;
                        acc_lo_q <= a_mag;
                        opnd_q   <= b_mag;
                        neg_q    <= op_signed && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                    end
                end
                MUL: begin
                    cnt_q                <= cnt_q + CW'(1);
                    {acc_hi_q, acc_lo_q} <= mul_acc_n;
                    if (last) begin
                        {hi_q, lo_q} <= mul_res;
                        done_q       <= 1'b1;
                    end
                end
`ifdef ALU_DIV_EN
                DIV: begin
                    cnt_q    <= cnt_q + CW'(1);
                    acc_hi_q <= rem_n;
                    acc_lo_q <= quo_n;
                    if (last) begin
                        hi_q   <= div_hi;
                        lo_q   <= div_lo;
                        done_q <= 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign hi_o   = hi_q;
    assign lo_o   = lo_q;
    assign busy_o = (state_q != IDLE);
    assign done_o = done_q;

endmodule

// File: rtl/alu_ext.sv
// Execute-stage ALU: combinational funct decode plus HI/LO mul/div unit (divider under ALU_DIV_EN).
// Latency: y_o/zero_o/ovf_o same cycle; MULT/DIV results land in HI/LO WIDTH cycles after start.
// Backpressure: controller stalls on busy_o; start_i while busy is ignored, no queuing.
module alu_ext
    import alu_ext_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic     clk_i,
    input  logic     rst_i,
    alu_ext_if.slave bus
);
    logic [WIDTH-1:0] a, b, sum, dif, hi, lo, y;
    logic [SHW-1:0]   sh;
    logic             add_ovf, sub_ovf, slt, sltu, md_sel, ovf;

    assign a       = bus.a_i;
    assign b       = bus.b_i;
    assign sh      = b[SHW-1:0];
    assign sum     = a + b;
    assign dif     = a - b;
    assign add_ovf = signed_ovf(a[WIDTH-1], b[WIDTH-1], sum[WIDTH-1], 1'b0);
    assign sub_ovf = signed_ovf(a[WIDTH-1], b[WIDTH-1], dif[WIDTH-1], 1'b1);
    assign slt     = $signed(a) < $signed(b);
    assign sltu    = a < b;
    assign md_sel  = (bus.funct_i6[5:2] == 4'b0110);

    always_comb begin
        y   = '0;
        ovf = 1'b0;
        case (bus.funct_i6)
            F_ADD:   begin y = sum; ovf = add_ovf; end
            F_ADDU:  y = sum;
            F_SUB:   begin y = dif; ovf = sub_ovf; end
            F_SUBU:  y = dif;
            F_AND:   y = a & b;
            F_OR:    y = a | b;
            F_XOR:   y = a ^ b;
            F_NOR:   y = ~(a | b);
            F_SLT:   y = {{(WIDTH-1){1'b0}}, slt};
            F_SLTU:  y = {{(WIDTH-1){1'b0}}, sltu};
            F_SLL:   y = a << sh;
            F_SRL:   y = a >> sh;
            F_SRA:   y = $signed(a) >>> sh;
            F_MFHI:  y = hi;
            F_MFLO:  y = lo;
            F_MULT, F_MULTU, F_DIV, F_DIVU: y = '0;
            default: begin
                case (alt_e'(bus.alt_ctrl_i2))
                    ALT_ADD: begin y = sum; ovf = add_ovf; end
                    ALT_SUB: begin y = dif; ovf = sub_ovf; end
                    ALT_SLT: y = {{(WIDTH-1){1'b0}}, slt};
                    default: y = '0;
                endcase
            end
        endcase
    end

    assign bus.y_o    = y;
    assign bus.zero_o = (y == '0);
    assign bus.ovf_o  = ovf;

    alu_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (bus.start_i && md_sel),
        .op_i    (bus.funct_i6[1:0]),
        .a_i     (a),
        .b_i     (b),
        .hi_o    (hi),
        .lo_o    (lo),
        .busy_o  (bus.busy_o),
        .done_o  (bus.done_o)
    );

endmodule
